fetch_sequencer: RTL and testbench

Pipeline control block that sequences the IF stage and IF/ID / ID/EX registers of the 5-stage RISC-V core. Drives the IF stage's `pc_src`, `pc_write_zero` and `dest_pc` controls. It produces:
- the post-reset boot hold,
- load-use stalls,
- taken-branch/jump redirects with flush,
- a debug halt/resume handshake that drains the pipeline.

It also keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/fetch_sequencer_if.sv | 43 ++++
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer and the IF/ID/EX datapath.
// The master side is the sequencer; the slave side is the pipeline.
interface fetch_sequencer_if #(
    parameter int PC_W = 16
);
    // Hazard / redirect / debug inputs seen by the sequencer
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic            ex_mem_read;
    logic [4:0]      ex_rd;
    logic            ex_branch_taken;
    logic [PC_W-1:0] ex_target;
    logic            halt_req;
    logic            resume;

    // Controls driven back into the pipeline
    logic            pc_src;
    logic [PC_W-1:0] dest_pc;
    logic            pc_write_zero;
    logic            ifid_write_en;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            halted;
    logic [15:0]     stall_count;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_rd, ex_branch_taken, ex_target,
        input  halt_req, resume,
        output pc_src, dest_pc, pc_write_zero, ifid_write_en,
        output ifid_flush, idex_bubble, halted, stall_count
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_rd, ex_branch_taken, ex_target,
        output halt_req, resume,
        input  pc_src, dest_pc, pc_write_zero, ifid_write_en,
        input  ifid_flush, idex_bubble, halted, stall_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: boot hold, load-use stall, branch redirect with flush,
// and a debug halt that drains the pipeline before reporting halted.
// Control outputs are combinational from the registered state and inputs.
module fetch_sequencer #(
    parameter int PC_W         = 16,
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);

    localparam int BOOT_W  = $clog2(BOOT_CYCLES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [BOOT_W-1:0]  BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [BOOT_W-1:0]    boot_cnt_reg, boot_cnt_next;
    logic [DRAIN_W-1:0]   drain_cnt_reg, drain_cnt_next;
    logic [15:0]          stall_count_reg, stall_count_next;

    // Load-use detection: one comparator per ID source operand
    logic [4:0] id_src [2];
    logic [1:0] id_uses;
    logic [1:0] src_hit;
    logic       load_use;

    assign id_src[0] = bus.id_rs1;
    assign id_src[1] = bus.id_rs2;
    assign id_uses   = {bus.id_uses_rs2, bus.id_uses_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = id_uses[gi] && (id_src[gi] == bus.ex_rd);
        end
    endgenerate

    // x0 is never a real destination, so a load to x0 cannot create a hazard
    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) && (|src_hit);

    assign bus.stall_count = stall_count_reg;

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_BOOT;
            boot_cnt_reg    <= '0;
            drain_cnt_reg   <= '0;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            boot_cnt_reg    <= boot_cnt_next;
            drain_cnt_reg   <= drain_cnt_next;
            stall_count_reg <= stall_count_next;
        end
    end

    // Next-state and counter update; redirect outranks stall outranks halt
    always_comb begin
        state_next       = state_reg;
        boot_cnt_next    = boot_cnt_reg;
        drain_cnt_next   = drain_cnt_reg;
        stall_count_next = stall_count_reg;
        case (state_reg)
            ST_BOOT: begin
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    boot_cnt_next = boot_cnt_reg + BOOT_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    state_next = ST_RUN;
                end else if (load_use) begin
                    if (stall_count_reg != 16'hFFFF) begin
                        stall_count_next = stall_count_reg + 16'd1;
                    end
                end else if (bus.halt_req) begin
                    drain_cnt_next = '0;
                    state_next     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A redirect here only steers the PC; the drain keeps counting
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = ST_HALT;
                end else begin
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Pipeline control outputs; default is the frozen/flushed boot pattern
    always_comb begin
        bus.pc_src        = 1'b0;
        bus.dest_pc       = {PC_W{1'b0}};
        bus.pc_write_zero = 1'b1;
        bus.ifid_write_en = 1'b0;
        bus.ifid_flush    = 1'b1;
        bus.idex_bubble   = 1'b1;
        bus.halted        = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    bus.pc_src        = 1'b1;
                    bus.dest_pc       = bus.ex_target;
                    bus.pc_write_zero = 1'b0;
                end else if (load_use) begin
                    bus.ifid_flush    = 1'b0;
                end else if (bus.halt_req) begin
                    bus.idex_bubble   = 1'b0;
                end else begin
                    bus.pc_write_zero = 1'b0;
                    bus.ifid_write_en = 1'b1;
                    bus.ifid_flush    = 1'b0;
                    bus.idex_bubble   = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Let a late redirect land in the PC so resume starts there
                if (bus.ex_branch_taken) begin
                    bus.pc_src        = 1'b1;
                    bus.dest_pc       = bus.ex_target;
                    bus.pc_write_zero = 1'b0;
                end
            end
            ST_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                bus.halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: constant vector table in RUN, hand-written
// boot/halt/drain/reset sequences, and randomized cycles against a
// countdown-based reference model with a small PC register model.
module tb_fetch_sequencer;

    localparam int PC_W         = 16;
    localparam int BOOT_CYCLES  = 2;
    localparam int DRAIN_CYCLES = 3;

    // {pc_src, dest_pc, pc_write_zero, ifid_write_en, ifid_flush, idex_bubble, halted, stall_count}
    localparam logic [37:0] BOOT_OUT = {1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};

    logic clk = 1'b0;
    logic reset;

    fetch_sequencer_if #(.PC_W(PC_W)) bus_if ();

    fetch_sequencer #(
        .PC_W(PC_W),
        .BOOT_CYCLES(BOOT_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining boot cycles, remaining drain cycles, halted flag
    int              boot_left;
    int              drain_left;
    bit              m_halted;
    int              m_stalls;
    logic [PC_W-1:0] pc;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        mr;
        logic [4:0]  rd;
        logic        br;
        logic [15:0] tgt;
        logic        hreq;
        logic        e_ps;
        logic [15:0] e_dp;
        logic        e_pz;
        logic        e_we;
        logic        e_fl;
        logic        e_bb;
        int          e_inc;
    } vec_t;

    vec_t tbl [10];

    function automatic bit hazard();
        return bus_if.ex_mem_read && (bus_if.ex_rd != 5'd0) &&
               ((bus_if.id_uses_rs1 && bus_if.id_rs1 == bus_if.ex_rd) ||
                (bus_if.id_uses_rs2 && bus_if.id_rs2 == bus_if.ex_rd));
    endfunction

    function automatic logic [37:0] model_out();
        logic        ps, pz, we, fl, bb, hl;
        logic [15:0] dp;
        ps = 1'b0; dp = 16'h0; pz = 1'b1; we = 1'b0; fl = 1'b1; bb = 1'b1; hl = 1'b0;
        if (!reset || boot_left > 0) begin
            ps = 1'b0;
        end else if (m_halted) begin
            hl = 1'b1;
        end else if (drain_left > 0) begin
            if (bus_if.ex_branch_taken) begin
                ps = 1'b1; dp = bus_if.ex_target; pz = 1'b0;
            end
        end else if (bus_if.ex_branch_taken) begin
            ps = 1'b1; dp = bus_if.ex_target; pz = 1'b0;
        end else if (hazard()) begin
            fl = 1'b0;
        end else if (bus_if.halt_req) begin
            bb = 1'b0;
        end else begin
            pz = 1'b0; we = 1'b1; fl = 1'b0; bb = 1'b0;
        end
        return {ps, dp, pz, we, fl, bb, hl, (reset ? 16'(m_stalls) : 16'h0)};
    endfunction

    function automatic logic [37:0] dut_out();
        return {bus_if.pc_src, bus_if.dest_pc, bus_if.pc_write_zero, bus_if.ifid_write_en,
                bus_if.ifid_flush, bus_if.idex_bubble, bus_if.halted, bus_if.stall_count};
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        boot_left  = BOOT_CYCLES;
        drain_left = 0;
        m_halted   = 1'b0;
        m_stalls   = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (boot_left > 0) begin
            boot_left--;
        end else if (m_halted) begin
            if (bus_if.resume) m_halted = 1'b0;
        end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) m_halted = 1'b1;
        end else if (bus_if.ex_branch_taken) begin
            m_halted = 1'b0;
        end else if (hazard()) begin
            if (m_stalls < 65535) m_stalls++;
        end else if (bus_if.halt_req) begin
            drain_left = DRAIN_CYCLES;
        end
    endtask

    task automatic clear_inputs();
        bus_if.id_rs1 = 5'd0; bus_if.id_rs2 = 5'd0;
        bus_if.id_uses_rs1 = 1'b0; bus_if.id_uses_rs2 = 1'b0;
        bus_if.ex_mem_read = 1'b0; bus_if.ex_rd = 5'd0;
        bus_if.ex_branch_taken = 1'b0; bus_if.ex_target = '0;
        bus_if.halt_req = 1'b0; bus_if.resume = 1'b0;
    endtask

    // Compare all outputs against the model on the falling edge
    task automatic sample(input string name);
        @(negedge clk);
        check(name, dut_out(), model_out());
    endtask

    // Clock edge: advance model and the IF PC register, then settle past the edge
    task automatic advance();
        logic [PC_W-1:0] pc_n;
        if (!reset)                      pc_n = '0;
        else if (bus_if.pc_src)          pc_n = bus_if.dest_pc;
        else if (!bus_if.pc_write_zero)  pc_n = pc + PC_W'(4);
        else                             pc_n = pc;
        @(posedge clk);
        model_edge();
        pc = pc_n;
        #1;
    endtask

    initial begin
        int              n;
        logic [PC_W-1:0] pc_before;

        //            rs1 rs2 u1 u2 mr rd br tgt      hq  ps dp       pz we fl bb inc
        tbl[0] = '{5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        tbl[1] = '{5'd0, 5'd5, 0, 1, 1, 5'd5, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 1};
        tbl[2] = '{5'd0, 5'd5, 0, 1, 0, 5'd5, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        tbl[3] = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        tbl[4] = '{5'd7, 5'd3, 1, 0, 1, 5'd7, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 1};
        tbl[5] = '{5'd7, 5'd7, 0, 0, 1, 5'd7, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        tbl[6] = '{5'd0, 5'd5, 0, 1, 1, 5'd5, 1, 16'h0040, 0, 1, 16'h0040, 0, 0, 1, 1, 0};
        tbl[7] = '{5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 16'h1234, 1, 1, 16'h1234, 0, 0, 1, 1, 0};
        tbl[8] = '{5'd4, 5'd9, 1, 1, 1, 5'd9, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1, 1};
        tbl[9] = '{5'd9, 5'd4, 1, 1, 1, 5'd9, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 1, 1};

        // Power-on reset held for three cycles
        reset = 1'b0;
        clear_inputs();
        model_reset();
        pc = '0;
        #1;
        check("reset_async", dut_out(), BOOT_OUT);
        for (int i = 0; i < 3; i++) begin
            sample("reset_hold");
            advance();
        end

        // Boot hold: PC frozen for exactly BOOT_CYCLES cycles
        reset = 1'b1;
        for (int i = 0; i <= BOOT_CYCLES; i++) begin
            sample("boot");
            check("boot_pcwz", {37'b0, bus_if.pc_write_zero}, {37'b0, (i < BOOT_CYCLES)});
            advance();
        end
        check("boot_stall_zero", {22'b0, bus_if.stall_count}, 38'd0);

        // Vector table applied in RUN
        n = 0;
        for (int v = 0; v < 10; v++) begin
            bus_if.id_rs1 = tbl[v].rs1; bus_if.id_rs2 = tbl[v].rs2;
            bus_if.id_uses_rs1 = tbl[v].u1; bus_if.id_uses_rs2 = tbl[v].u2;
            bus_if.ex_mem_read = tbl[v].mr; bus_if.ex_rd = tbl[v].rd;
            bus_if.ex_branch_taken = tbl[v].br; bus_if.ex_target = tbl[v].tgt;
            bus_if.halt_req = tbl[v].hreq; bus_if.resume = 1'b0;
            sample($sformatf("tbl%0d_model", v));
            check($sformatf("tbl%0d_ctrl", v),
                  {16'b0, bus_if.pc_src, bus_if.dest_pc, bus_if.pc_write_zero,
                   bus_if.ifid_write_en, bus_if.ifid_flush, bus_if.idex_bubble},
                  {16'b0, tbl[v].e_ps, tbl[v].e_dp, tbl[v].e_pz,
                   tbl[v].e_we, tbl[v].e_fl, tbl[v].e_bb});
            check($sformatf("tbl%0d_stall", v), {22'b0, bus_if.stall_count}, 38'(n));
            advance();
            n += tbl[v].e_inc;
        end
        clear_inputs();
        sample("tbl_after");
        check("tbl_stall_total", {22'b0, bus_if.stall_count}, 38'd4);
        advance();

        // Halt: drain, halted after DRAIN_CYCLES+1 cycles, then resume
        pc_before = pc;
        bus_if.halt_req = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            sample("halt_seq");
            if (bus_if.halted) break;
            advance();
            n++;
        end
        check("halt_latency", 38'(n), 38'(DRAIN_CYCLES + 1));
        check("halt_pc_frozen", 38'(pc), 38'(pc_before));
        bus_if.halt_req = 1'b0;
        bus_if.resume = 1'b1;
        advance();
        bus_if.resume = 1'b0;
        sample("resume");
        check("resume_halted_low", {37'b0, bus_if.halted}, 38'd0);
        check("resume_pc_runs", {37'b0, bus_if.pc_write_zero}, 38'd0);
        advance();
        check("resume_pc_incr", 38'(pc), 38'(pc_before + PC_W'(4)));

        // Redirect during DRAIN lands in the PC and is fetched first after resume
        bus_if.halt_req = 1'b1;
        sample("bd_accept");
        advance();
        bus_if.ex_branch_taken = 1'b1;
        bus_if.ex_target = 16'h0080;
        sample("bd_redirect");
        check("bd_redirect_ctrl", {20'b0, bus_if.pc_src, bus_if.dest_pc, bus_if.pc_write_zero},
              {20'b0, 1'b1, 16'h0080, 1'b0});
        advance();
        bus_if.ex_branch_taken = 1'b0;
        bus_if.ex_target = '0;
        for (int k = 0; k < 20; k++) begin
            sample("bd_drain");
            if (bus_if.halted) break;
            advance();
        end
        check("bd_halted", {37'b0, bus_if.halted}, 38'd1);
        check("bd_pc_at_halt", 38'(pc), 38'h80);
        bus_if.halt_req = 1'b0;
        bus_if.resume = 1'b1;
        advance();
        bus_if.resume = 1'b0;
        sample("bd_resume");
        check("bd_first_fetch", 38'(pc), 38'h80);
        advance();
        check("bd_next_fetch", 38'(pc), 38'h84);

        // Reset mid-DRAIN: immediate boot values, boot hold repeats
        bus_if.halt_req = 1'b1;
        sample("md_accept");
        advance();
        sample("md_drain");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("md_async_reset", dut_out(), BOOT_OUT);
        advance();
        bus_if.halt_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i <= BOOT_CYCLES; i++) begin
            sample("md_boot");
            check("md_boot_pcwz", {37'b0, bus_if.pc_write_zero}, {37'b0, (i < BOOT_CYCLES)});
            advance();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            if (!reset) model_reset();
            bus_if.id_rs1 = 5'($urandom_range(0, 3));
            bus_if.id_rs2 = 5'($urandom_range(0, 3));
            bus_if.id_uses_rs1 = 1'($urandom_range(0, 1));
            bus_if.id_uses_rs2 = 1'($urandom_range(0, 1));
            bus_if.ex_mem_read = ($urandom_range(0, 9) < 4);
            bus_if.ex_rd = 5'($urandom_range(0, 3));
            bus_if.ex_branch_taken = ($urandom_range(0, 99) < 15);
            bus_if.ex_target = PC_W'($urandom);
            if ($urandom_range(0, 15) == 0) bus_if.halt_req = ~bus_if.halt_req;
            bus_if.resume = ($urandom_range(0, 7) == 0);
            sample("rand");
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
